// File: rtl/t_counter_ctrl_if.sv
// rtl/t_counter_ctrl_if.sv - control/status bundle between register block and T-FF count sequencer
interface t_counter_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             stop;
  logic             up_down;
  logic             auto_rld;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] toggle;
  logic             busy;
  logic             tc_pulse;
  logic             done;

  modport master (
    output start, stop, up_down, auto_rld, load_val,
    input  count, toggle, busy, tc_pulse, done
  );

  modport slave (
    input  start, stop, up_down, auto_rld, load_val,
    output count, toggle, busy, tc_pulse, done
  );
endinterface

// File: rtl/t_counter_ctrl.sv
// rtl/t_counter_ctrl.sv - sequencer computing per-bit toggle vectors for a T-FF count bank
module t_counter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  t_counter_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q;
  logic             dir_q;
  logic             rld_q;
  logic             accept;

  logic [WIDTH-1:0] init_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] toggle;
  logic             busy;
  logic             tc_pulse;
  logic             done;

  // Ripple-toggle pattern of a binary counter: bit i flips when every lower
  // bit is at the carry (up) or borrow (down) value.
  function automatic logic [WIDTH-1:0] step_toggle(input logic [WIDTH-1:0] c,
                                                   input logic up);
    logic [WIDTH-1:0] t;
    logic             chain;
    t     = '0;
    chain = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]  = chain;
      chain = chain & (up ? c[i] : ~c[i]);
    end
    return t;
  endfunction

  assign init_val = dir_q ? '0 : lim_q;
  assign term_val = dir_q ? lim_q : '0;
  assign accept   = (state_q == S_IDLE) && bus.start && !bus.stop;

  // Next-state and toggle/status decode from state and current bank value
  always_comb begin
    state_d  = state_q;
    toggle   = '0;
    busy     = 1'b0;
    tc_pulse = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (bus.stop) begin
          state_d = S_IDLE;
        end else begin
          toggle  = count_q ^ init_val;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (count_q == term_val) begin
          tc_pulse = 1'b1;
          if (rld_q) toggle  = count_q ^ init_val;
          else       state_d = S_DONE;
        end else begin
          toggle = step_toggle(count_q, dir_q);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The bank itself: only ever written through the toggle vector
  assign count_d = count_q ^ toggle;

  // State, bank and captured pass parameters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      lim_q   <= '0;
      dir_q   <= 1'b0;
      rld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        lim_q <= bus.load_val;
        dir_q <= bus.up_down;
        rld_q <= bus.auto_rld;
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.toggle   = toggle;
  assign bus.busy     = busy;
  assign bus.tc_pulse = tc_pulse;
  assign bus.done     = done;

endmodule

// File: tb/tb_t_counter_ctrl.sv
// tb/tb_t_counter_ctrl.sv - directed-vector bench for t_counter_ctrl
module tb_t_counter_ctrl;
  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  t_counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

  t_counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_outs(input string tag, input logic [31:0] exp_count);
    chk({tag, " count"},    32'(bus.count), exp_count);
    chk({tag, " busy"},     32'(bus.busy), 0);
    chk({tag, " toggle"},   32'(bus.toggle), 0);
    chk({tag, " tc_pulse"}, 32'(bus.tc_pulse), 0);
    chk({tag, " done"},     32'(bus.done), 0);
  endtask

  task automatic launch(input logic up, input logic rld, input logic [WIDTH-1:0] lim);
    bus.start    = 1'b1;
    bus.up_down  = up;
    bus.auto_rld = rld;
    bus.load_val = lim;
    tick();
    bus.start    = 1'b0;
    bus.load_val = 8'hA5;
    bus.up_down  = ~up;
    bus.auto_rld = ~rld;
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.up_down  = 1'b0;
    bus.auto_rld = 1'b0;
    bus.load_val = '0;
    tick();
    tick();
    idle_outs("reset", 0);
    reset = 1'b0;
    tick();
    idle_outs("post_reset", 0);

    // Up count 0..3, one-shot
    launch(1'b1, 1'b0, 8'd3);
    chk("up3 load busy", 32'(bus.busy), 1);
    chk("up3 load toggle", 32'(bus.toggle), 0);
    for (int k = 0; k <= 3; k++) begin
      tick();
      chk($sformatf("up3 count%0d", k), 32'(bus.count), k);
      chk($sformatf("up3 tc%0d", k), 32'(bus.tc_pulse), (k == 3) ? 1 : 0);
      chk($sformatf("up3 done%0d", k), 32'(bus.done), 0);
    end
    tick();
    chk("up3 done", 32'(bus.done), 1);
    chk("up3 done busy", 32'(bus.busy), 0);
    chk("up3 done count", 32'(bus.count), 3);
    tick();
    idle_outs("up3 idle", 3);

    // Down count 5..0 from a bank holding 3
    launch(1'b0, 1'b0, 8'd5);
    chk("dn5 load toggle", 32'(bus.toggle), 6);
    for (int k = 5; k >= 0; k--) begin
      tick();
      chk($sformatf("dn5 count%0d", k), 32'(bus.count), k);
      chk($sformatf("dn5 tc%0d", k), 32'(bus.tc_pulse), (k == 0) ? 1 : 0);
    end
    tick();
    chk("dn5 done", 32'(bus.done), 1);
    tick();
    idle_outs("dn5 idle", 0);

    // Auto-reload up to 2: 0,1,2,0,1,2,...
    launch(1'b1, 1'b1, 8'd2);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("rld count%0d", k), 32'(bus.count), k % 3);
      chk($sformatf("rld tc%0d", k), 32'(bus.tc_pulse), (k % 3 == 2) ? 1 : 0);
      chk($sformatf("rld busy%0d", k), 32'(bus.busy), 1);
      chk($sformatf("rld done%0d", k), 32'(bus.done), 0);
    end
    bus.stop = 1'b1;
    #1;
    chk("rld stop toggle", 32'(bus.toggle), 0);
    tick();
    bus.stop = 1'b0;
    idle_outs("rld stopped", 2);

    // Abort at count 4 of an up pass to 9; start ignored while running
    launch(1'b1, 1'b0, 8'd9);
    for (int k = 0; k <= 4; k++) begin
      tick();
      chk($sformatf("stop count%0d", k), 32'(bus.count), k);
      if (k == 2) begin
        bus.start    = 1'b1;
        bus.load_val = 8'd1;
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    #1;
    chk("stop toggle", 32'(bus.toggle), 0);
    chk("stop tc", 32'(bus.tc_pulse), 0);
    tick();
    bus.stop = 1'b0;
    idle_outs("stopped", 4);
    tick();
    idle_outs("stopped hold", 4);

    // start together with stop stays in IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    idle_outs("start_stop", 4);
    tick();
    idle_outs("start_stop hold", 4);

    // lim = 0: a single RUN cycle with terminal count
    launch(1'b1, 1'b0, 8'd0);
    chk("lim0 load toggle", 32'(bus.toggle), 4);
    tick();
    chk("lim0 count", 32'(bus.count), 0);
    chk("lim0 tc", 32'(bus.tc_pulse), 1);
    chk("lim0 busy", 32'(bus.busy), 1);
    tick();
    chk("lim0 done", 32'(bus.done), 1);
    tick();
    idle_outs("lim0 idle", 0);

    // Full range up: reaches all-ones, never wraps
    launch(1'b1, 1'b0, 8'd255);
    for (int k = 0; k <= 255; k++) begin
      tick();
      if (bus.count !== 8'(k) || k == 0 || k == 254 || k == 255) begin
        chk($sformatf("full count%0d", k), 32'(bus.count), k);
        chk($sformatf("full tc%0d", k), 32'(bus.tc_pulse), (k == 255) ? 1 : 0);
      end
    end
    tick();
    chk("full done", 32'(bus.done), 1);
    chk("full done count", 32'(bus.count), 255);
    tick();
    idle_outs("full idle", 255);

    // Reset in the middle of a pass
    launch(1'b1, 1'b0, 8'd20);
    tick();
    for (int k = 1; k <= 7; k++) tick();
    chk("rst pre count", 32'(bus.count), 7);
    chk("rst pre busy", 32'(bus.busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_outs("rst mid", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
